arbitro2: RTL and testbench

Read-side counterpart of the four-channel input arbiter. Drains the four per-destination FIFOs that the input arbiter fills, selecting among non-empty channels round-robin and merging their 12-bit words into a single downstream FIFO, with back-pressure from that FIFO's almost-full flag. Keeps a wrapping word counter per channel for the checker.

---
 rtl/arbitro2_pkg.sv | 28 ++
 rtl/arbitro2_if.sv | 40 ++++
 rtl/arbitro2_rr_picker.sv | 32 +++
 rtl/arbitro2.sv | 89 ++++++++
 tb/tb_arbitro2.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro2_pkg.sv
// Shared types and constants for the four-channel read-side arbiter.
// Channel index and mask types are shared by the top and the round-robin picker.
package arbitro2_pkg;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int CW  = 8;
  localparam int RRW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [NCH-1:0] chmask_t;
  typedef logic [RRW-1:0] chidx_t;
  typedef logic [CW-1:0]  cnt_t;

  function automatic chidx_t onehot_to_idx(input chmask_t oh);
    chidx_t idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) idx = chidx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro2_if.sv
// Channel-FIFO / downstream-FIFO signal bundle of the read-side arbiter.
// slave is the arbiter side, master is the FIFO/environment side.
interface arbitro2_if;
  import arbitro2_pkg::*;

  logic                 active;
  logic [NCH-1:0]       emptyFIFO;
  logic [NCH*DW-1:0]    fifo_data;
  logic                 almost_fullOUT;
  logic [NCH-1:0]       pop;
  logic                 push;
  logic [DW-1:0]        data_out;
  logic                 idle;
  logic [NCH*CW-1:0]    count;

  modport slave (
    input  active,
    input  emptyFIFO,
    input  fifo_data,
    input  almost_fullOUT,
    output pop,
    output push,
    output data_out,
    output idle,
    output count
  );

  modport master (
    output active,
    output emptyFIFO,
    output fifo_data,
    output almost_fullOUT,
    input  pop,
    input  push,
    input  data_out,
    input  idle,
    input  count
  );

endinterface

// File: rtl/arbitro2_rr_picker.sv
// Combinational round-robin picker: first requesting channel starting at i_rr.
// o_next_rr points one past the winner so the winner gets lowest priority next.
module arbitro2_rr_picker
  import arbitro2_pkg::*;
(
  input  chidx_t  i_rr,
  input  chmask_t i_req,
  output chmask_t o_grant,
  output chidx_t  o_next_rr,
  output logic    o_any
);

  chidx_t w_cand;
  logic   w_found;

  always_comb begin
    o_grant   = '0;
    o_next_rr = i_rr;
    w_found   = 1'b0;
    w_cand    = i_rr;
    for (int k = 0; k < NCH; k++) begin
      w_cand = i_rr + chidx_t'(k);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_next_rr       = w_cand + chidx_t'(1);
        w_found         = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/arbitro2.sv
// Read-side arbiter: drains four channel FIFOs round-robin into one downstream FIFO.
// Pop in cycle N yields push/data_out in cycle N+1; per-channel 8-bit wrapping word counters.
module arbitro2
  import arbitro2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  arbitro2_if.slave  bus
);

  state_t  r_state;
  state_t  w_state_nxt;
  logic    w_arb_en;

  chidx_t  r_rr;
  chidx_t  r_sel;
  logic    r_push_q;
  cnt_t    r_cnt [NCH];

  chmask_t w_req;
  chmask_t w_grant;
  chidx_t  w_next_rr;
  logic    w_any;
  logic [DW-1:0] w_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration is enabled only in RUN while active is still high and the sink has room.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.active) w_state_nxt = RUN;
      end
      RUN: begin
        if (!bus.active) w_state_nxt = IDLE;
        w_arb_en = bus.active && !bus.almost_fullOUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_req = w_arb_en ? ~bus.emptyFIFO : '0;

  arbitro2_rr_picker u_picker (
    .i_rr      (r_rr),
    .i_req     (w_req),
    .o_grant   (w_grant),
    .o_next_rr (w_next_rr),
    .o_any     (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= '0;
      r_sel    <= '0;
      r_push_q <= 1'b0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      if (w_any) begin
        r_rr  <= w_next_rr;
        r_sel <= onehot_to_idx(w_grant);
      end
      r_push_q <= w_any;
      if (r_push_q) r_cnt[r_sel] <= r_cnt[r_sel] + cnt_t'(1);
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_push_q && (r_sel == chidx_t'(i))) w_data = bus.fifo_data[i*DW +: DW];
    end
  end

  assign bus.pop      = w_grant;
  assign bus.push     = r_push_q;
  assign bus.data_out = w_data;
  assign bus.idle     = ((r_state == IDLE) || (&bus.emptyFIFO)) && !r_push_q && !(|w_grant);

  for (genvar g = 0; g < NCH; g++) begin : g_count
    assign bus.count[g*CW +: CW] = r_cnt[g];
  end

endmodule

// File: tb/tb_arbitro2.sv
// Scoreboard bench for arbitro2: directed channel contents, expected words queued on load,
// a negedge monitor pops and compares every push.
module tb_arbitro2;
  import arbitro2_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro2_if bus();

  arbitro2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]  expq [$];
  logic [DW-1:0]  chq0 [$];
  logic [DW-1:0]  chq1 [$];
  logic [DW-1:0]  chq2 [$];
  logic [DW-1:0]  chq3 [$];
  logic [NCH-1:0] p_s;
  logic [DW-1:0]  m_exp;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  task automatic upd_empty();
    bus.emptyFIFO[0] = (chq0.size() == 0);
    bus.emptyFIFO[1] = (chq1.size() == 0);
    bus.emptyFIFO[2] = (chq2.size() == 0);
    bus.emptyFIFO[3] = (chq3.size() == 0);
  endtask

  // Channel FIFO model: word popped at an edge is presented on fifo_data right after it.
  task automatic adv();
    @(posedge clk);
    #1;
    if (p_s[0] && chq0.size() > 0) bus.fifo_data[0*DW +: DW] = chq0.pop_front();
    if (p_s[1] && chq1.size() > 0) bus.fifo_data[1*DW +: DW] = chq1.pop_front();
    if (p_s[2] && chq2.size() > 0) bus.fifo_data[2*DW +: DW] = chq2.pop_front();
    if (p_s[3] && chq3.size() > 0) bus.fifo_data[3*DW +: DW] = chq3.pop_front();
    upd_empty();
  endtask

  task automatic smp();
    @(negedge clk);
    p_s = bus.pop;
  endtask

  task automatic load(input int ch, input logic [DW-1:0] w);
    case (ch)
      0: chq0.push_back(w);
      1: chq1.push_back(w);
      2: chq2.push_back(w);
      default: chq3.push_back(w);
    endcase
    upd_empty();
  endtask

  task automatic expect_word(input logic [DW-1:0] w);
    expq.push_back(w);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.active = 1'b0;
    bus.almost_fullOUT = 1'b0;
    chq0.delete(); chq1.delete(); chq2.delete(); chq3.delete();
    expq.delete();
    p_s = '0;
    bus.fifo_data = '0;
    upd_empty();
    smp();
    adv();
    smp();
    adv();
    reset = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((expq.size() != 0 || bus.push) && c < maxc) begin
      adv();
      smp();
      c++;
    end
    adv();
    smp();
    chk("drain_expq_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.push === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_push", {20'h0, bus.data_out}, 32'hFFFF_FFFF);
      end else begin
        m_exp = expq.pop_front();
        chk("data_out", {20'h0, bus.data_out}, {20'h0, m_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] t1_pops [5];
    t1_pops = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1;
    bus.active = 1'b0;
    bus.almost_fullOUT = 1'b0;
    bus.emptyFIFO = '1;
    bus.fifo_data = '0;
    p_s = '0;

    // reset state
    do_reset();
    smp();
    chk("rst_pop",   {28'h0, bus.pop}, 32'h0);
    chk("rst_push",  {31'h0, bus.push}, 32'h0);
    chk("rst_data",  {20'h0, bus.data_out}, 32'h0);
    chk("rst_count", bus.count, 32'h0);
    chk("rst_idle",  {31'h0, bus.idle}, 32'h1);

    // all four channels busy: strict round robin from channel 0
    adv();
    bus.active = 1'b1;
    load(0, 12'h100); load(0, 12'h101); load(1, 12'h200); load(2, 12'h300); load(3, 12'h400);
    expect_word(12'h100); expect_word(12'h200); expect_word(12'h300);
    expect_word(12'h400); expect_word(12'h101);
    smp();
    chk("t1_idle_nopop", {28'h0, bus.pop}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      adv();
      smp();
      chk("t1_pop_seq", {28'h0, bus.pop}, {28'h0, t1_pops[k]});
    end
    drain(20);
    chk("t1_count", bus.count, 32'h0101_0102);

    // only channel 2 holds words
    do_reset();
    adv();
    bus.active = 1'b1;
    load(2, 12'h301); load(2, 12'h302); load(2, 12'h303);
    expect_word(12'h301); expect_word(12'h302); expect_word(12'h303);
    smp();
    for (int k = 0; k < 3; k++) begin
      adv();
      smp();
      chk("t2_pop_ch2", {28'h0, bus.pop}, 32'h4);
    end
    adv();
    smp();
    chk("t2_pop_done", {28'h0, bus.pop}, 32'h0);
    drain(10);
    chk("t2_count", bus.count, 32'h0003_0000);

    // almost-full during an in-flight push
    do_reset();
    adv();
    bus.active = 1'b1;
    load(0, 12'h010); load(0, 12'h011); load(1, 12'h020);
    expect_word(12'h010); expect_word(12'h020); expect_word(12'h011);
    smp();
    adv();
    smp();
    chk("t3_first_pop", {28'h0, bus.pop}, 32'h1);
    adv();
    bus.almost_fullOUT = 1'b1;
    smp();
    chk("t3_af_block",  {28'h0, bus.pop}, 32'h0);
    chk("t3_push_thru", {31'h0, bus.push}, 32'h1);
    adv();
    smp();
    chk("t3_af_hold", {28'h0, bus.pop}, 32'h0);
    chk("t3_no_push", {31'h0, bus.push}, 32'h0);
    adv();
    bus.almost_fullOUT = 1'b0;
    smp();
    chk("t3_resume_rr", {28'h0, bus.pop}, 32'h2);
    adv();
    smp();
    chk("t3_next_rr", {28'h0, bus.pop}, 32'h1);
    drain(10);

    // active dropped while streaming channel 3
    do_reset();
    adv();
    bus.active = 1'b1;
    load(3, 12'h401); load(3, 12'h402); load(3, 12'h403); load(3, 12'h404);
    expect_word(12'h401); expect_word(12'h402);
    smp();
    chk("t4_first_idle", {28'h0, bus.pop}, 32'h0);
    adv();
    smp();
    chk("t4_pop_a", {28'h0, bus.pop}, 32'h8);
    adv();
    smp();
    chk("t4_pop_b", {28'h0, bus.pop}, 32'h8);
    adv();
    bus.active = 1'b0;
    smp();
    chk("t4_no_pop",    {28'h0, bus.pop}, 32'h0);
    chk("t4_last_push", {31'h0, bus.push}, 32'h1);
    adv();
    smp();
    chk("t4_push_clear", {31'h0, bus.push}, 32'h0);
    chk("t4_idle",       {31'h0, bus.idle}, 32'h1);
    drain(5);

    // counter wrap on channel 1
    do_reset();
    adv();
    bus.active = 1'b1;
    for (int k = 0; k < 256; k++) begin
      load(1, 12'(k));
      expect_word(12'(k));
    end
    smp();
    drain(300);
    chk("t5_wrap_256", bus.count, 32'h0);
    adv();
    load(1, 12'hABC);
    expect_word(12'hABC);
    smp();
    drain(10);
    chk("t5_wrap_257", bus.count, 32'h0000_0100);

    // reset during a pop cycle drops the pending push
    do_reset();
    adv();
    bus.active = 1'b1;
    load(1, 12'h2AA);
    smp();
    adv();
    reset = 1'b1;
    smp();
    chk("t6_pop_at_rst", {28'h0, bus.pop}, 32'h2);
    adv();
    reset = 1'b0;
    smp();
    chk("t6_push_drop", {31'h0, bus.push}, 32'h0);
    chk("t6_count_clr", bus.count, 32'h0);
    chk("t6_idle",      {31'h0, bus.idle}, 32'h1);
    adv();
    load(0, 12'h111); load(1, 12'h222);
    expect_word(12'h111); expect_word(12'h222);
    smp();
    chk("t6_rr_restart", {28'h0, bus.pop}, 32'h1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
